mpu_req_arbiter: RTL and testbench

Multi-core front end for the MPU: accepts independent allocate/free requests from every core, picks one with a round-robin arbiter, and drives the MPU's single-requester command interface (core id, fr, masks, block count, address). It sequences each operation through issue and completion, and returns a one-hot done pulse with the resulting base address to the winning core. It sits between the core request fabric and the MPU top and owns all access to it.

---
 rtl/mpu_req_arbiter_if.sv | 46 ++++
 rtl/mpu_req_arbiter.sv | 155 +++++++++++++++
 tb/tb_mpu_req_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpu_req_arbiter_if.sv
// Core request fabric + MPU command bundle for mpu_req_arbiter.
// slave = arbiter side, master = the cores/MPU that surround it.
interface mpu_req_arbiter_if #(
  parameter int CORE_COUNT       = 4,
  parameter int CORE_ID_WIDTH    = 2,
  parameter int ADDR_WIDTH       = 32,
  parameter int BLOCK_COUNT_BITS = 8
);
  logic [CORE_COUNT-1:0]                  req_valid;
  logic [CORE_COUNT-1:0]                  req_fr;
  logic [CORE_COUNT*BLOCK_COUNT_BITS-1:0] req_num_blocks;
  logic [CORE_COUNT*ADDR_WIDTH-1:0]       req_addr;
  logic [CORE_COUNT*CORE_COUNT-1:0]       req_read_mask;
  logic [CORE_COUNT*CORE_COUNT-1:0]       req_write_mask;
  logic [CORE_COUNT-1:0]                  resp_done;
  logic [ADDR_WIDTH-1:0]                  resp_base_addr;
  logic                                   resp_err;
  logic [CORE_ID_WIDTH-1:0]               grant_id;
  logic                                   arb_bsy;
  logic                                   mpu_start;
  logic [CORE_ID_WIDTH-1:0]               mpu_core_id;
  logic                                   mpu_fr;
  logic [BLOCK_COUNT_BITS-1:0]            mpu_num_blocks;
  logic [ADDR_WIDTH-1:0]                  mpu_addr;
  logic [CORE_COUNT-1:0]                  mpu_read_mask;
  logic [CORE_COUNT-1:0]                  mpu_write_mask;
  logic                                   mpu_rdy;
  logic                                   mpu_bsy;
  logic [ADDR_WIDTH-1:0]                  mpu_base_addr;

  modport slave (
    input  req_valid, req_fr, req_num_blocks, req_addr, req_read_mask, req_write_mask,
    input  mpu_rdy, mpu_bsy, mpu_base_addr,
    output resp_done, resp_base_addr, resp_err, grant_id, arb_bsy,
    output mpu_start, mpu_core_id, mpu_fr, mpu_num_blocks, mpu_addr,
    output mpu_read_mask, mpu_write_mask
  );

  modport master (
    output req_valid, req_fr, req_num_blocks, req_addr, req_read_mask, req_write_mask,
    output mpu_rdy, mpu_bsy, mpu_base_addr,
    input  resp_done, resp_base_addr, resp_err, grant_id, arb_bsy,
    input  mpu_start, mpu_core_id, mpu_fr, mpu_num_blocks, mpu_addr,
    input  mpu_read_mask, mpu_write_mask
  );
endinterface

// File: rtl/mpu_req_arbiter.sv
// Round-robin front end serialising per-core allocate/free requests onto the MPU command port.
// Optional WAIT watchdog: define MPU_ARB_TIMEOUT_EN.
module mpu_req_arbiter #(
  parameter int CORE_COUNT       = 4,
  parameter int CORE_ID_WIDTH    = 2,
  parameter int ADDR_WIDTH       = 32,
  parameter int BLOCK_COUNT_BITS = 8,
  parameter int TIMEOUT_CYCLES   = 256
) (
  input logic              clk,
  input logic              rst,
  mpu_req_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                      state_reg;
  logic [CORE_ID_WIDTH-1:0]    rr_ptr_reg;
  logic [CORE_ID_WIDTH-1:0]    grant_reg;
  logic [CORE_COUNT-1:0]       resp_done_reg;
  logic [ADDR_WIDTH-1:0]       resp_base_reg;
  logic                        arb_bsy_reg;
  logic                        mpu_start_reg;
  logic                        mpu_fr_reg;
  logic [BLOCK_COUNT_BITS-1:0] mpu_nb_reg;
  logic [ADDR_WIDTH-1:0]       mpu_addr_reg;
  logic [CORE_COUNT-1:0]       mpu_rmask_reg;
  logic [CORE_COUNT-1:0]       mpu_wmask_reg;

  logic [BLOCK_COUNT_BITS-1:0] nb_arr    [CORE_COUNT];
  logic [ADDR_WIDTH-1:0]       addr_arr  [CORE_COUNT];
  logic [CORE_COUNT-1:0]       rmask_arr [CORE_COUNT];
  logic [CORE_COUNT-1:0]       wmask_arr [CORE_COUNT];
  logic [CORE_ID_WIDTH-1:0]    rot_idx   [CORE_COUNT];
  logic [CORE_COUNT-1:0]       rot_valid;
  logic [CORE_ID_WIDTH-1:0]    sel;

  if (CORE_COUNT < 2 || (1 << CORE_ID_WIDTH) < CORE_COUNT || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mpu_req_arbiter: inconsistent parameters");
  end

  // rot_idx[k] is the core k places after rr_ptr, so rot_valid is the request vector seen from rr_ptr
  for (genvar gi = 0; gi < CORE_COUNT; gi++) begin : g_core
    logic [CORE_ID_WIDTH:0] sum;
    assign nb_arr[gi]    = bus.req_num_blocks[gi*BLOCK_COUNT_BITS +: BLOCK_COUNT_BITS];
    assign addr_arr[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign rmask_arr[gi] = bus.req_read_mask[gi*CORE_COUNT +: CORE_COUNT];
    assign wmask_arr[gi] = bus.req_write_mask[gi*CORE_COUNT +: CORE_COUNT];
    assign sum           = {1'b0, rr_ptr_reg} + (CORE_ID_WIDTH+1)'(gi);
    assign rot_idx[gi]   = (sum >= (CORE_ID_WIDTH+1)'(CORE_COUNT))
                         ? CORE_ID_WIDTH'(sum - (CORE_ID_WIDTH+1)'(CORE_COUNT))
                         : sum[CORE_ID_WIDTH-1:0];
    assign rot_valid[gi] = bus.req_valid[rot_idx[gi]];
  end

  always_comb begin
    sel = rot_idx[0];
    for (int k = CORE_COUNT - 1; k >= 0; k--) begin
      if (rot_valid[k]) sel = rot_idx[k];
    end
  end

`ifdef MPU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             resp_err_reg;
  logic             timeout_hit;
  assign timeout_hit = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      resp_done_reg <= '0;
      resp_base_reg <= '0;
      arb_bsy_reg   <= 1'b0;
      mpu_start_reg <= 1'b0;
      mpu_fr_reg    <= 1'b0;
      mpu_nb_reg    <= '0;
      mpu_addr_reg  <= '0;
      mpu_rmask_reg <= '0;
      mpu_wmask_reg <= '0;
`ifdef MPU_ARB_TIMEOUT_EN
      wait_cnt_reg  <= '0;
      resp_err_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (|bus.req_valid && !bus.mpu_bsy) begin
            grant_reg     <= sel;
            mpu_fr_reg    <= bus.req_fr[sel];
            mpu_nb_reg    <= nb_arr[sel];
            mpu_addr_reg  <= addr_arr[sel];
            mpu_rmask_reg <= rmask_arr[sel];
            mpu_wmask_reg <= wmask_arr[sel];
            mpu_start_reg <= 1'b1;
            arb_bsy_reg   <= 1'b1;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          mpu_start_reg <= 1'b0;
          state_reg     <= WAIT;
`ifdef MPU_ARB_TIMEOUT_EN
          wait_cnt_reg  <= '0;
`endif
        end
        WAIT: begin
          // a completion arriving on the watchdog limit still counts as success
          if (bus.mpu_rdy) begin
            resp_base_reg <= bus.mpu_base_addr;
            resp_done_reg <= CORE_COUNT'(1) << grant_reg;
            state_reg     <= RESP;
`ifdef MPU_ARB_TIMEOUT_EN
            resp_err_reg  <= 1'b0;
          end else if (timeout_hit) begin
            resp_base_reg <= '0;
            resp_err_reg  <= 1'b1;
            resp_done_reg <= CORE_COUNT'(1) << grant_reg;
            state_reg     <= RESP;
          end else begin
            wait_cnt_reg  <= wait_cnt_reg + 1'b1;
`endif
          end
        end
        RESP: begin
          resp_done_reg <= '0;
          arb_bsy_reg   <= 1'b0;
          rr_ptr_reg    <= (grant_reg == CORE_ID_WIDTH'(CORE_COUNT - 1)) ? '0 : grant_reg + 1'b1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.resp_done      = resp_done_reg;
  assign bus.resp_base_addr = resp_base_reg;
  assign bus.grant_id       = grant_reg;
  assign bus.arb_bsy        = arb_bsy_reg;
  assign bus.mpu_start      = mpu_start_reg;
  assign bus.mpu_core_id    = grant_reg;
  assign bus.mpu_fr         = mpu_fr_reg;
  assign bus.mpu_num_blocks = mpu_nb_reg;
  assign bus.mpu_addr       = mpu_addr_reg;
  assign bus.mpu_read_mask  = mpu_rmask_reg;
  assign bus.mpu_write_mask = mpu_wmask_reg;
`ifdef MPU_ARB_TIMEOUT_EN
  assign bus.resp_err       = resp_err_reg;
`else
  assign bus.resp_err       = 1'b0;
`endif
endmodule

// File: tb/tb_mpu_req_arbiter.sv
// Directed + randomized bench for mpu_req_arbiter; an operation-level model checks every cycle.
module tb_mpu_req_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int AW  = 32;
  localparam int BW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mpu_req_arbiter_if #(.CORE_COUNT(N), .CORE_ID_WIDTH(IDW), .ADDR_WIDTH(AW), .BLOCK_COUNT_BITS(BW)) bus ();

  mpu_req_arbiter #(
    .CORE_COUNT(N), .CORE_ID_WIDTH(IDW), .ADDR_WIDTH(AW), .BLOCK_COUNT_BITS(BW), .TIMEOUT_CYCLES(256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int c, input logic fr, input logic [BW-1:0] nb,
                          input logic [AW-1:0] addr, input logic [N-1:0] rm, input logic [N-1:0] wm);
    bus.req_fr[c]                  = fr;
    bus.req_num_blocks[c*BW +: BW] = nb;
    bus.req_addr[c*AW +: AW]       = addr;
    bus.req_read_mask[c*N +: N]    = rm;
    bus.req_write_mask[c*N +: N]   = wm;
  endtask

  task automatic wait_start();
    int cnt = 0;
    while (bus.mpu_start !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    check("start_seen", 64'(bus.mpu_start), 64'd1);
  endtask

  // Operation-level model: an op is granted, counts its age in cycles, completes on the first
  // mpu_rdy at age >= 2, pulses done for one cycle, then frees the port one cycle later.
  bit              m_active = 0;
  bit              m_done   = 0;
  int              m_age    = 0;
  int              m_g      = 0;
  int              m_rr     = 0;
  logic [N-1:0]    e_done   = '0;
  logic [AW-1:0]   e_base   = '0;
  logic [IDW-1:0]  e_grant  = '0;
  logic            e_bsy    = 1'b0;
  logic            e_start  = 1'b0;
  logic            e_fr     = 1'b0;
  logic [BW-1:0]   e_nb     = '0;
  logic [AW-1:0]   e_addr   = '0;
  logic [N-1:0]    e_rm     = '0;
  logic [N-1:0]    e_wm     = '0;

  initial begin
    forever begin
      logic            s_rst, s_rdy, s_bsy;
      logic [N-1:0]    s_valid, s_fr;
      logic [N*BW-1:0] s_nb;
      logic [N*AW-1:0] s_addr;
      logic [N*N-1:0]  s_rm, s_wm;
      logic [AW-1:0]   s_base;
      @(posedge clk);
      s_rst = rst;  s_rdy = bus.mpu_rdy;  s_bsy = bus.mpu_bsy;  s_base = bus.mpu_base_addr;
      s_valid = bus.req_valid;  s_fr = bus.req_fr;  s_nb = bus.req_num_blocks;
      s_addr = bus.req_addr;  s_rm = bus.req_read_mask;  s_wm = bus.req_write_mask;
      e_start = 1'b0;
      e_done  = '0;
      if (s_rst) begin
        m_active = 0;  m_done = 0;  m_rr = 0;
        e_base = '0;  e_grant = '0;  e_fr = 1'b0;  e_nb = '0;  e_addr = '0;  e_rm = '0;  e_wm = '0;
      end else if (m_active) begin
        m_age++;
        if (m_done) begin
          m_active = 0;
          m_rr = (m_g + 1) % N;
        end else if (m_age >= 2 && s_rdy) begin
          m_done = 1;
          e_base = s_base;
          e_done = N'(1) << m_g;
        end
      end else if (|s_valid && !s_bsy) begin
        for (int i = 0; i < N; i++) begin
          if (s_valid[(m_rr + i) % N]) begin
            m_g = (m_rr + i) % N;
            break;
          end
        end
        m_active = 1;  m_done = 0;  m_age = 0;
        e_start = 1'b1;
        e_grant = IDW'(m_g);
        e_fr    = s_fr[m_g];
        e_nb    = s_nb[m_g*BW +: BW];
        e_addr  = s_addr[m_g*AW +: AW];
        e_rm    = s_rm[m_g*N +: N];
        e_wm    = s_wm[m_g*N +: N];
      end
      e_bsy = m_active;
      #3;
      if (e_done != 0) $display("txn core=%0d base=%08h", m_g, e_base);
      check("resp_done",      64'(bus.resp_done),      64'(e_done));
      check("resp_base_addr", 64'(bus.resp_base_addr), 64'(e_base));
      check("resp_err",       64'(bus.resp_err),       64'd0);
      check("grant_id",       64'(bus.grant_id),       64'(e_grant));
      check("arb_bsy",        64'(bus.arb_bsy),        64'(e_bsy));
      check("mpu_start",      64'(bus.mpu_start),      64'(e_start));
      check("mpu_core_id",    64'(bus.mpu_core_id),    64'(e_grant));
      check("mpu_fr",         64'(bus.mpu_fr),         64'(e_fr));
      check("mpu_num_blocks", 64'(bus.mpu_num_blocks), 64'(e_nb));
      check("mpu_addr",       64'(bus.mpu_addr),       64'(e_addr));
      check("mpu_read_mask",  64'(bus.mpu_read_mask),  64'(e_rm));
      check("mpu_write_mask", 64'(bus.mpu_write_mask), 64'(e_wm));
    end
  end

  bit [N-1:0] pend;

  initial begin
    bus.req_valid = '0;  bus.req_fr = '0;  bus.req_num_blocks = '0;  bus.req_addr = '0;
    bus.req_read_mask = '0;  bus.req_write_mask = '0;
    bus.mpu_rdy = 1'b0;  bus.mpu_bsy = 1'b0;  bus.mpu_base_addr = '0;
    rst = 1'b1;
    repeat (3) tick();
    check("reset_done", 64'(bus.resp_done), 64'd0);
    check("reset_bsy",  64'(bus.arb_bsy),   64'd0);
    rst = 1'b0;

    // single allocate from core 2
    set_core(2, 1'b1, 8'd4, 32'h0, 4'hF, 4'h3);
    bus.req_valid = 4'b0100;
    tick();
    check("t1_start",   64'(bus.mpu_start),      64'd1);
    check("t1_core",    64'(bus.mpu_core_id),    64'd2);
    check("t1_fr",      64'(bus.mpu_fr),         64'd1);
    check("t1_nb",      64'(bus.mpu_num_blocks), 64'd4);
    check("t1_bsy",     64'(bus.arb_bsy),        64'd1);
    tick();
    check("t1_start_off", 64'(bus.mpu_start), 64'd0);
    bus.mpu_rdy = 1'b1;  bus.mpu_base_addr = 32'h40;
    tick();
    check("t1_done", 64'(bus.resp_done),      64'h4);
    check("t1_base", 64'(bus.resp_base_addr), 64'h40);
    bus.mpu_rdy = 1'b0;  bus.req_valid = '0;
    tick();
    check("t1_done_off", 64'(bus.resp_done), 64'd0);
    check("t1_bsy_off",  64'(bus.arb_bsy),   64'd0);

    // free from core 1; mpu_rdy during ISSUE must be ignored
    set_core(1, 1'b0, 8'd9, 32'h80, 4'h1, 4'h2);
    bus.req_valid = 4'b0010;
    tick();
    check("t2_start", 64'(bus.mpu_start), 64'd1);
    check("t2_fr",    64'(bus.mpu_fr),    64'd0);
    check("t2_addr",  64'(bus.mpu_addr),  64'h80);
    bus.mpu_rdy = 1'b1;  bus.mpu_base_addr = 32'h999;
    tick();
    check("t2_start_once", 64'(bus.mpu_start), 64'd0);
    check("t2_issue_rdy",  64'(bus.resp_done), 64'd0);
    bus.mpu_base_addr = 32'h1234;
    tick();
    check("t2_done", 64'(bus.resp_done),      64'h2);
    check("t2_base", 64'(bus.resp_base_addr), 64'h1234);
    bus.mpu_rdy = 1'b0;  bus.req_valid = '0;
    tick();

    // MPU busy blocks the grant
    bus.mpu_bsy = 1'b1;
    set_core(0, 1'b1, 8'd2, 32'h0, 4'h0, 4'h0);
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_blocked_start", 64'(bus.mpu_start), 64'd0);
    end
    bus.mpu_bsy = 1'b0;
    tick();
    check("t3_start", 64'(bus.mpu_start), 64'd1);
    check("t3_grant", 64'(bus.grant_id),  64'd0);
    tick();
    bus.mpu_rdy = 1'b1;  bus.mpu_base_addr = 32'h55;
    tick();
    check("t3_done", 64'(bus.resp_done), 64'h1);
    bus.mpu_rdy = 1'b0;  bus.req_valid = '0;
    tick();

    // round robin with all cores held valid from reset
    rst = 1'b1;
    tick();
    bus.req_valid = 4'hF;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      wait_start();
      check("rr_grant", 64'(bus.mpu_core_id), 64'(n % N));
      tick();
      bus.mpu_rdy = 1'b1;  bus.mpu_base_addr = 32'(n + 1);
      tick();
      check("rr_done", 64'(bus.resp_done), 64'(1 << (n % N)));
      bus.mpu_rdy = 1'b0;
    end
    bus.req_valid = '0;
    repeat (2) tick();

    // reset while waiting on the MPU
    set_core(3, 1'b1, 8'd7, 32'hC0, 4'h8, 4'h8);
    bus.req_valid = 4'b1000;
    wait_start();
    check("t5_core", 64'(bus.mpu_core_id), 64'd3);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("t5_rst_done",  64'(bus.resp_done),      64'd0);
    check("t5_rst_bsy",   64'(bus.arb_bsy),        64'd0);
    check("t5_rst_grant", 64'(bus.grant_id),       64'd0);
    check("t5_rst_nb",    64'(bus.mpu_num_blocks), 64'd0);
    check("t5_rst_addr",  64'(bus.mpu_addr),       64'd0);
    check("t5_rst_base",  64'(bus.resp_base_addr), 64'd0);
    rst = 1'b0;
    wait_start();
    check("t5_regrant", 64'(bus.mpu_core_id), 64'd3);
    tick();
    bus.mpu_rdy = 1'b1;  bus.mpu_base_addr = 32'hABC;
    tick();
    check("t5_done", 64'(bus.resp_done), 64'h8);
    bus.mpu_rdy = 1'b0;  bus.req_valid = '0;
    tick();

    // randomized traffic, model-checked
    pend = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (bus.resp_done[i]) pend[i] = ($urandom_range(1, 0) == 1);
        else if (!pend[i])    pend[i] = ($urandom_range(3, 0) == 0);
      end
      bus.req_valid      = pend;
      bus.req_fr         = N'($urandom);
      bus.req_num_blocks = $urandom;
      bus.req_addr       = {$urandom, $urandom, $urandom, $urandom};
      bus.req_read_mask  = 16'($urandom);
      bus.req_write_mask = 16'($urandom);
      bus.mpu_rdy        = ($urandom_range(2, 0) == 0);
      bus.mpu_bsy        = ($urandom_range(7, 0) == 0);
      bus.mpu_base_addr  = $urandom;
      rst                = ($urandom_range(499, 0) == 0);
      tick();
    end
    rst = 1'b0;
    bus.req_valid = '0;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
